// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scanner.
// Contents:
//   ST_GAP / ST_SHOW  - state encoding of the scan FSM
//   scan_state_t      - enum built on that encoding
//   DEF_DIV           - per-digit lit time for a 50 MHz board clock (1 kHz slot rate)
//   DEF_GAP_CYC       - default all-off dead time between digits
package disp_pkg;

    localparam logic ST_GAP  = 1'b0;
    localparam logic ST_SHOW = 1'b1;

    typedef enum logic {
        S_GAP  = ST_GAP,
        S_SHOW = ST_SHOW
    } scan_state_t;

    localparam int unsigned BOARD_CLK_HZ = 32'd50_000_000;
    localparam int unsigned SLOT_HZ      = 32'd1_000;
    localparam int unsigned DEF_DIV      = BOARD_CLK_HZ / SLOT_HZ;
    localparam int unsigned DEF_GAP_CYC  = 32'd2;

endpackage

// File: rtl/lz_mask.sv
// Leading-zero blanking mask for the display scanner.
// Ports:
//   shadow   [4*DIGITS-1:0] in  - latched display word, nibble 0 is rightmost
//   blank_lz                in  - enable leading-zero blanking
//   blank    [DIGITS-1:0]   out - bit i set when digit i must stay dark
// Digit i (i >= 1) is blanked when it and every digit to its left are zero.
// Digit 0 is never blanked so a zero value still shows a single "0".
module lz_mask
    import disp_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] shadow,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   blank
);

    logic zero_above_s;

    // Walk from the leftmost digit downwards, accumulating "everything so far is zero".
    always_comb begin
        blank        = {DIGITS{1'b0}};
        zero_above_s = blank_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above_s = zero_above_s & (shadow[4*i +: 4] == 4'h0);
            blank[i]     = zero_above_s;
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Ports:
//   CLK       in  - system clock
//   RST_N     in  - synchronous active-low reset
//   LOAD      in  - capture DATA into the shadow register at this edge
//   DATA      in  - display word, nibble 0 (bits 3:0) is the rightmost digit
//   BLANK_LZ  in  - blank leading-zero digits
//   NIBBLE    out - hex value of the currently selected digit, to the decoder
//   DIGIT_EN  out - active-low digit enables, at most one bit low
// Each digit gets a slot of GAP_CYC all-off cycles followed by DIV lit cycles.
// Blanked digits keep their slot so frame timing never depends on the data.
module seg_scan
    import disp_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIV     = DEF_DIV,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] DATA,
    input  logic                BLANK_LZ,
    output logic [3:0]          NIBBLE,
    output logic [DIGITS-1:0]   DIGIT_EN
);

    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CMAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
    localparam int CW   = $clog2(CMAX);

    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    scan_state_t         state_r;
    scan_state_t         state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic [IW-1:0]       idx_r;
    logic [IW-1:0]       idx_nxt_s;
    logic [4*DIGITS-1:0] shadow_r;
    logic [DIGITS-1:0]   blank_s;

    // Shadow register: CPU word, cleared by reset, recaptured on every LOAD edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shadow_r <= {(4*DIGITS){1'b0}};
        end else if (LOAD) begin
            shadow_r <= DATA;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Scan FSM state, slot counter and digit index registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= S_GAP;
            cnt_r   <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic: GAP for GAP_CYC cycles, SHOW for DIV cycles, then advance digit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CW'(1);
        idx_nxt_s   = idx_r;
        case (state_r)
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = S_SHOW;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            S_SHOW: begin
                if (cnt_r == DIV_LAST) begin
                    state_nxt_s = S_GAP;
                    cnt_nxt_s   = {CW{1'b0}};
                    idx_nxt_s   = (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
                end else begin
                    state_nxt_s = S_SHOW;
                end
            end
            default: begin
                state_nxt_s = S_GAP;
                cnt_nxt_s   = {CW{1'b0}};
                idx_nxt_s   = {IW{1'b0}};
            end
        endcase
    end

    lz_mask #(
        .DIGITS(DIGITS)
    ) u_lz_mask (
        .shadow  (shadow_r),
        .blank_lz(BLANK_LZ),
        .blank   (blank_s)
    );

    // Output decode: nibble follows idx in both states; a digit lights only in SHOW when not blanked.
    always_comb begin
        NIBBLE   = 4'(shadow_r >> {idx_r, 2'b00});
        DIGIT_EN = {DIGITS{1'b1}};
        if ((state_r == S_SHOW) && !blank_s[idx_r]) begin
            DIGIT_EN[idx_r] = 1'b0;
        end else begin
            DIGIT_EN = {DIGITS{1'b1}};
        end
    end

endmodule
